// File: rtl/roi_pkg.sv
// Shared definitions for the ROI maximum scanner: FSM state encoding and default sizing.
package roi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned N_CH_DEF = 8;
    localparam int unsigned W_DEF    = 8;

endpackage

// File: rtl/roi_max_cmp.sv
// Strict compare-and-select of (energy, index) pairs; ties keep the current (earlier) entry.
module roi_max_cmp #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [W-1:0]  cur_e,
    input  logic [IW-1:0] cur_idx,
    input  logic [W-1:0]  new_e,
    input  logic [IW-1:0] new_idx,
    output logic [W-1:0]  sel_e,
    output logic [IW-1:0] sel_idx
);

    logic take;

    assign take    = new_e > cur_e;
    assign sel_e   = take ? new_e   : cur_e;
    assign sel_idx = take ? new_idx : cur_idx;

endmodule

// File: rtl/roi_max_scanner.sv
// Scans a frame of per-channel energies and reports the peak channel, its energy,
// a threshold hit flag, the sample count and a truncation error, with a valid/ready result.
module roi_max_scanner
    import roi_pkg::*;
#(
    parameter  int unsigned N_CH = N_CH_DEF,
    parameter  int unsigned W    = W_DEF,
    localparam int unsigned IW   = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_e,
    input  logic          in_last,
    input  logic [W-1:0]  thresh,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_roi,
    output logic [W-1:0]  out_emax,
    output logic          out_hit,
    output logic [IW:0]   out_nch,
    output logic          out_err
);

    state_t        state;
    state_t        state_nxt;
    logic [IW:0]   count;
    logic [IW:0]   count_inc;
    logic [W-1:0]  max_e;
    logic [IW-1:0] roi;
    logic [W-1:0]  thr;
    logic          err;
    logic          accept;
    logic          at_limit;
    logic [W-1:0]  sel_e;
    logic [IW-1:0] sel_idx;

    assign accept    = in_valid && in_ready;
    assign count_inc = count + 1'b1;
    assign at_limit  = (count_inc == (IW+1)'(N_CH));

    // In SCAN the count never exceeds N_CH-1, so its low IW bits are the arriving index
    roi_max_cmp #(
        .W  (W),
        .IW (IW)
    ) u_cmp (
        .cur_e   (max_e),
        .cur_idx (roi),
        .new_e   (in_e),
        .new_idx (count[IW-1:0]),
        .sel_e   (sel_e),
        .sel_idx (sel_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = in_last ? HOLD : SCAN;
            SCAN: if (accept && (in_last || at_limit)) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            max_e <= '0;
            roi   <= '0;
            thr   <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                count <= (IW+1)'(1);
                max_e <= in_e;
                roi   <= '0;
                thr   <= thresh;
                err   <= 1'b0;
            end else begin
                count <= count_inc;
                max_e <= sel_e;
                roi   <= sel_idx;
                err   <= !in_last && at_limit;
            end
        end
    end

    assign out_roi  = roi;
    assign out_emax = max_e;
    assign out_hit  = (max_e > thr);
    assign out_nch  = count;
    assign out_err  = err;

endmodule

// File: doc/roi_max_scanner.md
ROI_MAX_SCANNER -- requirements
Module: roi_max_scanner

Interface
REQ-001 Parameter N_CH, default 8: number of channels per frame; SHALL be >= 2.
REQ-002 Parameter W, default 8: unsigned energy width in bits.
REQ-003 Derived constant IW = max(1, clog2(N_CH)): index width.
REQ-004 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 IN_VALID  in  1  energy sample present.
REQ-007 IN_READY  out  1  scanner accepts a sample this cycle.
REQ-008 IN_E  in  W  channel energy; channel index is the arrival order within the frame, starting at 0.
REQ-009 IN_LAST  in  1  marks the final sample of a frame.
REQ-010 THRESH  in  W  hit threshold; sampled once, on the first beat of each frame.
REQ-011 OUT_VALID  out  1  result available.
REQ-012 OUT_READY  in  1  consumer accepts the result.
REQ-013 OUT_ROI  out  IW  index of the maximum-energy channel.
REQ-014 OUT_EMAX  out  W  maximum energy in the frame.
REQ-015 OUT_HIT  out  1  set when OUT_EMAX > latched threshold.
REQ-016 OUT_NCH  out  IW+1  number of samples in the frame.
REQ-017 OUT_ERR  out  1  set when the frame was truncated at N_CH samples without IN_LAST.

Function
REQ-018 A beat SHALL be accepted when IN_VALID and IN_READY are both high.
REQ-019 States: IDLE (no frame open), SCAN (frame open), HOLD (result waiting for handshake).
REQ-020 IDLE: IN_READY=1; an accepted beat SHALL load max=IN_E, roi=0, count=1, latch THRESH, and go to SCAN. If IN_LAST is also high, go directly to HOLD.
REQ-021 SCAN: IN_READY=1; on an accepted beat, if IN_E > max, then max=IN_E and roi=count; count increments.
REQ-022 Ties SHALL keep the earlier index (strict greater-than), so equal energies select the lowest channel.
REQ-023 A frame SHALL close on an accepted beat with IN_LAST=1, or on the N_CH-th accepted beat, whichever occurs first.
REQ-024 A frame closed at N_CH beats with IN_LAST=0 SHALL set OUT_ERR=1. The next accepted beat starts a new frame.
REQ-025 On frame close, the next state SHALL be HOLD, with OUT_VALID=1 in the cycle after the closing beat (latency 1 cycle).
REQ-026 HOLD: IN_READY=0; outputs SHALL be stable until OUT_VALID and OUT_READY are both high, then the next state SHALL be IDLE.
REQ-027 There is no bypass from HOLD to SCAN; a new frame may start the cycle after the handshake, giving a minimum period of frame length + 1 cycles.
REQ-028 OUT_HIT SHALL be computed from the threshold latched on the first beat; THRESH changes mid-frame have no effect.
REQ-029 IN_VALID low in SCAN SHALL stall without changing state; there is no timeout.
REQ-030 OUT_ROI, OUT_EMAX, OUT_HIT, OUT_NCH and OUT_ERR SHALL reflect registered state only; no combinational path from inputs to outputs except through IN_READY, which depends only on state.

Reset
REQ-031 RST high SHALL force state IDLE, IN_READY=1 (after deassertion), OUT_VALID=0, OUT_ROI=0, OUT_EMAX=0, OUT_HIT=0, OUT_NCH=0, OUT_ERR=0, and clear the internal count, max and threshold.
REQ-032 Reset mid-frame or in HOLD SHALL discard the partial frame or pending result; no result is emitted for it.

Structure
REQ-033 Package roi_pkg SHALL hold the state encoding (IDLE, SCAN, HOLD) and the default N_CH and W values.
REQ-034 One sub-module, roi_max_cmp (W-bit strict compare-and-select of energy and index), SHALL be instantiated once for the running maximum.

Verification
REQ-035 N_CH=4, W=8, frame {10,40,25,30} with LAST on beat 3, THRESH=35 -> OUT_ROI=1, OUT_EMAX=40, OUT_HIT=1, OUT_NCH=4, OUT_ERR=0, OUT_VALID one cycle after beat 3.
REQ-036 Frame {50,50,20,50}, THRESH=50 -> OUT_ROI=0 (tie rule), OUT_HIT=0 (not strictly greater).
REQ-037 Single-beat frame {7} with LAST, THRESH=0 -> OUT_ROI=0, OUT_NCH=1, OUT_HIT=1; hold OUT_READY=0 for 5 cycles -> outputs stable and IN_READY=0 throughout.
REQ-038 N_CH=4, five beats {1,2,3,4,9} with no LAST -> first result OUT_ROI=3, OUT_EMAX=4, OUT_ERR=1; after the handshake, beat 9 with LAST -> OUT_ROI=0, OUT_EMAX=9, OUT_NCH=1, OUT_ERR=0.
REQ-039 Assert RST after 2 beats of a frame, then send frame {3,255} with LAST -> exactly one result: OUT_ROI=1, OUT_EMAX=255.
REQ-040 Random IN_VALID/OUT_READY gaps, N_CH=8, W=12, 1000 frames -> every result matches a reference-model maximum with the lowest-index tie rule.
